// File: rtl/id_branch_fwd_ctrl_pkg.sv
// Shared pipeline definitions for the ID-stage branch bypass and hazard controller.
package pipe_pkg;

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_EX  = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;
    localparam logic [1:0] SEL_WB  = 2'd3;

    localparam int OP_RTYPE  = 0;
    localparam int OP_REGIMM = 1;
    localparam int OP_JAL    = 3;
    localparam int OP_BEQ    = 4;
    localparam int OP_BNE    = 5;
    localparam int OP_BLEZ   = 6;
    localparam int OP_BGTZ   = 7;
    localparam int FN_JR     = 8;
    localparam int FN_JALR   = 9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } fwd_state_e;

    function automatic logic [1:0] req_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/id_branch_fwd_ctrl_if.sv
// Signal bundle between the ID stage / pipeline registers and the branch bypass controller.
// stall_count exists only when FWD_STALL_CNT_EN is defined.
interface id_branch_fwd_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int OP_W   = 6
);
    logic              id_valid;
    logic [OP_W-1:0]   OpCode;
    logic [OP_W-1:0]   Funct;
    logic [REG_AW-1:0] Rs;
    logic [REG_AW-1:0] Rt;
    logic              ID_EX_RegWrite;
    logic              ID_EX_MemRead;
    logic [REG_AW-1:0] ID_EX_Write_Addr;
    logic              EX_MEM_RegWrite;
    logic              EX_MEM_MemRead;
    logic [REG_AW-1:0] EX_MEM_Write_Addr;
    logic              MEM_WB_RegWrite;
    logic [REG_AW-1:0] MEM_WB_Write_Addr;
    logic [1:0]        Select_Rs;
    logic [1:0]        Select_Rt;
    logic              Select_ALU;
    logic              Stall;
`ifdef FWD_STALL_CNT_EN
    logic [31:0]       stall_count;
`endif

    modport master (
        output id_valid, OpCode, Funct, Rs, Rt,
               ID_EX_RegWrite, ID_EX_MemRead, ID_EX_Write_Addr,
               EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_Write_Addr,
               MEM_WB_RegWrite, MEM_WB_Write_Addr,
        input  Select_Rs, Select_Rt, Select_ALU, Stall
`ifdef FWD_STALL_CNT_EN
               , stall_count
`endif
    );

    modport slave (
        input  id_valid, OpCode, Funct, Rs, Rt,
               ID_EX_RegWrite, ID_EX_MemRead, ID_EX_Write_Addr,
               EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_Write_Addr,
               MEM_WB_RegWrite, MEM_WB_Write_Addr,
        output Select_Rs, Select_Rt, Select_ALU, Stall
`ifdef FWD_STALL_CNT_EN
               , stall_count
`endif
    );

endinterface

// File: rtl/id_branch_fwd_ctrl_fwd_src_match.sv
// One ID source operand: picks the youngest in-flight producer and reports how many
// stall cycles a load producer still needs before it can be forwarded. Purely combinational.
module fwd_src_match
    import pipe_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 2
) (
    input  logic              used_i,
    input  logic [REG_AW-1:0] src_i,
    input  logic              ex_we_i,
    input  logic              ex_rd_i,
    input  logic [REG_AW-1:0] ex_addr_i,
    input  logic              mem_we_i,
    input  logic              mem_rd_i,
    input  logic [REG_AW-1:0] mem_addr_i,
    input  logic              wb_we_i,
    input  logic [REG_AW-1:0] wb_addr_i,
    output logic [1:0]        sel_o,
    output logic [1:0]        req_o
);

    localparam logic [1:0] LAT_EX  = 2'(LOAD_LAT);
    localparam logic [1:0] LAT_MEM = 2'(LOAD_LAT - 1);

    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    // Register 0 is hardwired, so a write to it is never a producer.
    assign ex_hit  = ex_we_i  && (ex_addr_i  != '0) && (ex_addr_i  == src_i);
    assign mem_hit = mem_we_i && (mem_addr_i != '0) && (mem_addr_i == src_i);
    assign wb_hit  = wb_we_i  && (wb_addr_i  != '0) && (wb_addr_i  == src_i);

    always_comb begin
        sel_o = SEL_RF;
        req_o = 2'd0;
        if (used_i) begin
            if (ex_hit) begin
                sel_o = SEL_EX;
            end else if (mem_hit) begin
                sel_o = SEL_MEM;
            end else if (wb_hit) begin
                sel_o = SEL_WB;
            end

            if (ex_hit && ex_rd_i) begin
                req_o = LAT_EX;
            end else if (!ex_hit && mem_hit && mem_rd_i) begin
                req_o = LAT_MEM;
            end
        end
    end

endmodule

// File: rtl/id_branch_fwd_ctrl.sv
// ID-stage Rs/Rt bypass select and load-use stall sequencer for branches and jump-register.
// Selects are combinational; Stall holds IF/ID for the load latency. FWD_STALL_CNT_EN adds stall_count.
module id_branch_fwd_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int OP_W     = 6,
    parameter int LOAD_LAT = 2
) (
    input  logic                clk,
    input  logic                reset,
    id_branch_fwd_ctrl_if.slave bus
);

    logic [OP_W-1:0] op;
    logic [OP_W-1:0] fn;
    logic            is_rtype;
    logic            uses_rs;
    logic            uses_rt;
    logic [1:0]      sel_rs;
    logic [1:0]      sel_rt;
    logic [1:0]      req_rs;
    logic [1:0]      req_rt;
    logic [1:0]      req;
    logic            stall_req;
    logic            stall;

    fwd_state_e      state_q;
    logic [1:0]      cnt_q;

    assign op       = bus.OpCode;
    assign fn       = bus.Funct;
    assign is_rtype = (op == OP_W'(OP_RTYPE));

    assign uses_rs = (is_rtype && (fn == OP_W'(FN_JR) || fn == OP_W'(FN_JALR)))
                   || (op == OP_W'(OP_REGIMM))
                   || (op == OP_W'(OP_BEQ))
                   || (op == OP_W'(OP_BNE))
                   || (op == OP_W'(OP_BLEZ))
                   || (op == OP_W'(OP_BGTZ));

    assign uses_rt = (op == OP_W'(OP_BEQ)) || (op == OP_W'(OP_BNE));

    fwd_src_match #(
        .REG_AW   (REG_AW),
        .LOAD_LAT (LOAD_LAT)
    ) u_rs (
        .used_i     (uses_rs),
        .src_i      (bus.Rs),
        .ex_we_i    (bus.ID_EX_RegWrite),
        .ex_rd_i    (bus.ID_EX_MemRead),
        .ex_addr_i  (bus.ID_EX_Write_Addr),
        .mem_we_i   (bus.EX_MEM_RegWrite),
        .mem_rd_i   (bus.EX_MEM_MemRead),
        .mem_addr_i (bus.EX_MEM_Write_Addr),
        .wb_we_i    (bus.MEM_WB_RegWrite),
        .wb_addr_i  (bus.MEM_WB_Write_Addr),
        .sel_o      (sel_rs),
        .req_o      (req_rs)
    );

    fwd_src_match #(
        .REG_AW   (REG_AW),
        .LOAD_LAT (LOAD_LAT)
    ) u_rt (
        .used_i     (uses_rt),
        .src_i      (bus.Rt),
        .ex_we_i    (bus.ID_EX_RegWrite),
        .ex_rd_i    (bus.ID_EX_MemRead),
        .ex_addr_i  (bus.ID_EX_Write_Addr),
        .mem_we_i   (bus.EX_MEM_RegWrite),
        .mem_rd_i   (bus.EX_MEM_MemRead),
        .mem_addr_i (bus.EX_MEM_Write_Addr),
        .wb_we_i    (bus.MEM_WB_RegWrite),
        .wb_addr_i  (bus.MEM_WB_Write_Addr),
        .sel_o      (sel_rt),
        .req_o      (req_rt)
    );

    assign req       = req_max(req_rs, req_rt);
    assign stall_req = bus.id_valid && (req != 2'd0);

    // The first stall cycle is raised from IDLE; HOLD covers the remaining req-1 cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (stall_req && (req > 2'd1)) begin
                        state_q <= ST_HOLD;
                        cnt_q   <= req - 2'd1;
                    end
                end
                ST_HOLD: begin
                    cnt_q <= cnt_q - 2'd1;
                    if (cnt_q <= 2'd1) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 2'd0;
                end
            endcase
        end
    end

    // Gating with reset lets a mid-HOLD reset release the pipeline without waiting for an edge.
    assign stall = !reset && ((state_q == ST_HOLD) || stall_req);

    assign bus.Select_Rs  = sel_rs;
    assign bus.Select_Rt  = sel_rt;
    assign bus.Select_ALU = (op == OP_W'(OP_JAL)) || (is_rtype && (fn == OP_W'(FN_JALR)));
    assign bus.Stall      = stall;

`ifdef FWD_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    assign stall_cnt_d = (stall_cnt_q == 32'hFFFF_FFFF) ? stall_cnt_q : stall_cnt_q + 32'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else if (stall) begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_branch_fwd_ctrl.sv
// Scoreboard bench for id_branch_fwd_ctrl: directed cases plus randomized traffic
// against a stall-budget reference model.
module tb_id_branch_fwd_ctrl;

    localparam int LOAD_LAT = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    id_branch_fwd_ctrl_if #(.REG_AW(5), .OP_W(6)) bus ();

    id_branch_fwd_ctrl #(
        .REG_AW   (5),
        .OP_W     (6),
        .LOAD_LAT (LOAD_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       vld;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       exw;
        logic       exm;
        logic [4:0] exa;
        logic       mw;
        logic       mm;
        logic [4:0] ma;
        logic       ww;
        logic [4:0] wa;
    } stim_t;

    typedef struct {
        int      srs;
        int      srt;
        int      alu;
        int      stall;
        longint  cnt;
        string   name;
    } exp_t;

    exp_t   exp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     hold_left = 0;
    longint sc = 0;

    function automatic stim_t mk(int vld, int op, int fn, int rs, int rt,
                                 int exw, int exm, int exa,
                                 int mw, int mm, int ma, int ww, int wa);
        stim_t s;
        s.vld = 1'(vld);  s.op = 6'(op);   s.fn = 6'(fn);
        s.rs  = 5'(rs);   s.rt = 5'(rt);
        s.exw = 1'(exw);  s.exm = 1'(exm); s.exa = 5'(exa);
        s.mw  = 1'(mw);   s.mm = 1'(mm);   s.ma = 5'(ma);
        s.ww  = 1'(ww);   s.wa = 5'(wa);
        return s;
    endfunction

    function automatic exp_t hx(int srs, int srt, int alu, int st, string nm);
        exp_t e;
        e.srs = srs; e.srt = srt; e.alu = alu; e.stall = st; e.cnt = 0; e.name = nm;
        return e;
    endfunction

    // Reference rules: which operands an instruction reads, who produces them, and
    // how many cycles a load producer is still away from the WB bypass.
    function automatic bit uses_rs(stim_t s);
        return (s.op == 6'd0 && (s.fn == 6'd8 || s.fn == 6'd9)) ||
               (s.op inside {6'd1, 6'd4, 6'd5, 6'd6, 6'd7});
    endfunction

    function automatic bit uses_rt(stim_t s);
        return s.op inside {6'd4, 6'd5};
    endfunction

    function automatic int src_sel(logic [4:0] src, stim_t s);
        if (src == 5'd0) return 0;
        if (s.exw && s.exa == src) return 1;
        if (s.mw && s.ma == src) return 2;
        if (s.ww && s.wa == src) return 3;
        return 0;
    endfunction

    function automatic int src_req(logic [4:0] src, stim_t s);
        if (src == 5'd0) return 0;
        if (s.exw && s.exa == src) return s.exm ? LOAD_LAT : 0;
        if (s.mw && s.ma == src && s.mm) return LOAD_LAT - 1;
        return 0;
    endfunction

    task automatic apply(stim_t s);
        bus.id_valid          = s.vld;
        bus.OpCode            = s.op;
        bus.Funct             = s.fn;
        bus.Rs                = s.rs;
        bus.Rt                = s.rt;
        bus.ID_EX_RegWrite    = s.exw;
        bus.ID_EX_MemRead     = s.exm;
        bus.ID_EX_Write_Addr  = s.exa;
        bus.EX_MEM_RegWrite   = s.mw;
        bus.EX_MEM_MemRead    = s.mm;
        bus.EX_MEM_Write_Addr = s.ma;
        bus.MEM_WB_RegWrite   = s.ww;
        bus.MEM_WB_Write_Addr = s.wa;
    endtask

    // One pipeline cycle: drive inputs, push the expected response, advance the model.
    task automatic step(stim_t s, logic rst, bit has_hand, exp_t hand);
        exp_t e;
        int   req;
        @(posedge clk);
        #1;
        apply(s);
        reset = rst;
        req = 0;
        if (uses_rs(s)) req = src_req(s.rs, s);
        if (uses_rt(s) && src_req(s.rt, s) > req) req = src_req(s.rt, s);
        e.srs   = uses_rs(s) ? src_sel(s.rs, s) : 0;
        e.srt   = uses_rt(s) ? src_sel(s.rt, s) : 0;
        e.alu   = (s.op == 6'd3 || (s.op == 6'd0 && s.fn == 6'd9)) ? 1 : 0;
        e.stall = (!rst && (hold_left > 0 || (s.vld && req > 0))) ? 1 : 0;
        e.cnt   = rst ? 0 : sc;
        e.name  = "rand";
        if (has_hand) begin
            hand.cnt = e.cnt;
            exp_q.push_back(hand);
        end else begin
            exp_q.push_back(e);
        end
        if (rst) begin
            hold_left = 0;
            sc = 0;
        end else begin
            if (hold_left > 0) hold_left = hold_left - 1;
            else if (s.vld && req > 0) hold_left = req - 1;
            if (e.stall == 1 && sc < 64'hFFFF_FFFF) sc = sc + 1;
        end
    endtask

    task automatic chk(string nm, string fld, longint got, longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s %s: got %0d expected %0d", nm, fld, got, want);
        end
    endtask

    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, "Select_Rs", longint'(bus.Select_Rs), e.srs);
                chk(e.name, "Select_Rt", longint'(bus.Select_Rt), e.srt);
                chk(e.name, "Select_ALU", longint'(bus.Select_ALU), e.alu);
                chk(e.name, "Stall", longint'(bus.Stall), e.stall);
`ifdef FWD_STALL_CNT_EN
                chk(e.name, "stall_count", longint'(bus.stall_count), e.cnt);
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t z;
        int    ops[10] = '{0, 0, 1, 3, 4, 5, 6, 7, 2, 35};
        z = mk(0,0,0,0,0, 0,0,0, 0,0,0, 0,0);
        apply(z);

        step(z, 1, 1, hx(0,0,0,0, "reset"));
        step(z, 0, 1, hx(0,0,0,0, "post_reset"));

        // add $3 in EX, beq $3,$4
        step(mk(1,4,0,3,4, 1,0,3, 0,0,0, 0,0), 0, 1, hx(1,0,0,0, "alu_ex_beq"));
        // lw $5 in EX, jr $5; pipeline advances with a bubble behind the load
        step(mk(1,0,8,5,0, 1,1,5, 0,0,0, 0,0), 0, 1, hx(1,0,0,1, "lw_ex_c0"));
        step(mk(1,0,8,5,0, 0,0,0, 1,1,5, 0,0), 0, 1, hx(2,0,0,1, "lw_ex_c1"));
        step(mk(1,0,8,5,0, 0,0,0, 0,0,0, 1,5), 0, 1, hx(3,0,0,0, "lw_ex_c2"));
        // lw $6 in MEM, bne $7,$6
        step(mk(1,5,0,7,6, 0,0,0, 1,1,6, 0,0), 0, 1, hx(0,2,0,1, "lw_mem_c0"));
        step(mk(1,5,0,7,6, 0,0,0, 0,0,0, 1,6), 0, 1, hx(0,3,0,0, "lw_mem_c1"));
        // $2 in every stage, bgtz $2; then a write to $0 with jr $0
        step(mk(1,7,0,2,0, 1,0,2, 1,0,2, 1,2), 0, 1, hx(1,0,0,0, "prio_ex"));
        step(mk(1,0,8,0,0, 1,1,0, 1,1,0, 1,0), 0, 1, hx(0,0,0,0, "reg0"));
        // reset pulsed in the first HOLD cycle
        step(mk(1,0,8,5,0, 1,1,5, 0,0,0, 0,0), 0, 1, hx(1,0,0,1, "rst_c0"));
        step(mk(1,0,8,5,0, 0,0,0, 1,1,5, 0,0), 1, 1, hx(2,0,0,0, "rst_hold"));
        step(mk(0,0,8,5,0, 0,0,0, 0,0,0, 0,0), 0, 1, hx(0,0,0,0, "rst_idle"));
        // link-address select
        step(mk(1,3,0,0,0, 0,0,0, 0,0,0, 0,0), 0, 1, hx(0,0,1,0, "jal"));
        step(mk(1,0,9,8,0, 0,0,0, 0,0,0, 0,0), 0, 1, hx(0,0,1,0, "jalr"));
        step(mk(1,4,0,8,9, 0,0,0, 0,0,0, 0,0), 0, 1, hx(0,0,0,0, "beq_alu"));
        // Rs needs 2 cycles, Rt needs 1: the longer requirement wins
        step(mk(1,4,0,5,6, 1,1,5, 1,1,6, 0,0), 0, 1, hx(1,2,0,1, "dual_c0"));
        step(mk(1,4,0,5,6, 0,0,0, 1,1,5, 1,6), 0, 1, hx(2,3,0,1, "dual_c1"));
        step(mk(1,4,0,5,6, 0,0,0, 0,0,0, 1,5), 0, 1, hx(3,0,0,0, "dual_c2"));
        // bubble in ID never starts a stall but lets an active HOLD finish
        step(mk(0,4,0,5,0, 1,1,5, 0,0,0, 0,0), 0, 1, hx(1,0,0,0, "bubble_idle"));
        step(mk(1,0,8,5,0, 1,1,5, 0,0,0, 0,0), 0, 1, hx(1,0,0,1, "bubble_c0"));
        step(mk(0,0,8,5,0, 0,0,0, 1,1,5, 0,0), 0, 1, hx(2,0,0,1, "bubble_c1"));
        step(mk(0,0,8,5,0, 0,0,0, 0,0,0, 1,5), 0, 1, hx(3,0,0,0, "bubble_c2"));

        for (int i = 0; i < 2000; i++) begin
            stim_t s;
            int    op;
            int    fn;
            op = ops[$urandom_range(0, 9)];
            if (op == 0) fn = ($urandom_range(0, 3) == 0) ? 32 : ($urandom_range(0, 1) ? 8 : 9);
            else         fn = $urandom_range(0, 63);
            s = mk(($urandom_range(0, 9) != 0) ? 1 : 0, op, fn,
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 3));
            step(s, ($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0, 0, hx(0,0,0,0, "rand"));
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
